sram_ctl: RTL and testbench

SRAM_CTL -- requirements
Module: sram_ctl

---
 rtl/sram_ctl.sv | 183 ++++++++++++++++++
 tb/tb_sram_ctl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/sram_ctl.sv
// 32-bit bus to 16-bit asynchronous SRAM bridge: each word access is split into
// a low and a high half-word access separated by a one-cycle write-enable gap.
module sram_ctl #(
  parameter int ADDR_WIDTH  = 18,
  parameter int WAIT_STATES = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sval,
  output logic                  srdy,
  input  logic [31:0]           saddr,
  input  logic [31:0]           sdtw,
  output logic [31:0]           sdtr,
  input  logic                  srw,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  input  logic [15:0]           sram_din,
  output logic [15:0]           sram_dout,
  output logic                  sram_doe,
  output logic                  sram_nce,
  output logic                  sram_noe,
  output logic                  sram_nwe
);

  localparam int         HW = ADDR_WIDTH - 1;
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ACC0 = 3'd1,
    GAP  = 3'd2,
    ACC1 = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t          state_r, state_s;
  logic [3:0]      cnt_r, cnt_s;
  logic [HW-1:0]   addr_r, addr_s;
  logic [31:0]     data_r, data_s;
  logic            rw_r, rw_s;
  logic [31:0]     sdtr_s;
  logic            srdy_s, nce_s, noe_s, nwe_s, doe_s;
  logic [ADDR_WIDTH-1:0] sram_addr_s;
  logic [15:0]     dout_s;

  // Byte-lane bits and bits above the SRAM range are deliberately dropped.
  logic unused_bits;
  assign unused_bits = ^{saddr[31:ADDR_WIDTH+1], saddr[1:0]};

  // Next-state, request latch, wait counter and read-data capture.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    addr_s  = addr_r;
    data_s  = data_r;
    rw_s    = rw_r;
    sdtr_s  = sdtr;
    case (state_r)
      IDLE: begin
        if (sval) begin
          addr_s  = saddr[ADDR_WIDTH:2];
          data_s  = sdtw;
          rw_s    = srw;
          cnt_s   = WS;
          state_s = ACC0;
        end else begin
          state_s = IDLE;
        end
      end
      ACC0: begin
        if (cnt_r == 4'd0) begin
          state_s = GAP;
          if (!rw_r) begin
            sdtr_s[15:0] = sram_din;
          end else begin
            sdtr_s = sdtr;
          end
        end else begin
          cnt_s = cnt_r - 4'd1;
        end
      end
      GAP: begin
        state_s = ACC1;
        cnt_s   = WS;
      end
      ACC1: begin
        if (cnt_r == 4'd0) begin
          state_s = DONE;
          if (!rw_r) begin
            sdtr_s[31:16] = sram_din;
          end else begin
            sdtr_s = sdtr;
          end
        end else begin
          cnt_s = cnt_r - 4'd1;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
        cnt_s   = 4'd0;
      end
    endcase
  end

  // Pin values are decoded from the upcoming state so they can be registered.
  always_comb begin
    srdy_s      = 1'b0;
    nce_s       = 1'b1;
    noe_s       = 1'b1;
    nwe_s       = 1'b1;
    doe_s       = 1'b0;
    sram_addr_s = sram_addr;
    dout_s      = sram_dout;
    case (state_s)
      ACC0: begin
        nce_s       = 1'b0;
        noe_s       = rw_s;
        nwe_s       = ~rw_s;
        doe_s       = rw_s;
        sram_addr_s = {addr_s, 1'b0};
        dout_s      = data_s[15:0];
      end
      GAP: begin
        nce_s       = 1'b0;
        noe_s       = rw_s;
        nwe_s       = 1'b1;
        doe_s       = rw_s;
        sram_addr_s = {addr_s, 1'b1};
        dout_s      = data_s[15:0];
      end
      ACC1: begin
        nce_s       = 1'b0;
        noe_s       = rw_s;
        nwe_s       = ~rw_s;
        doe_s       = rw_s;
        sram_addr_s = {addr_s, 1'b1};
        dout_s      = data_s[31:16];
      end
      DONE: begin
        srdy_s = 1'b1;
      end
      default: begin
        srdy_s = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      cnt_r     <= 4'd0;
      addr_r    <= '0;
      data_r    <= 32'd0;
      rw_r      <= 1'b0;
      sdtr      <= 32'd0;
      srdy      <= 1'b0;
      sram_nce  <= 1'b1;
      sram_noe  <= 1'b1;
      sram_nwe  <= 1'b1;
      sram_doe  <= 1'b0;
      sram_addr <= '0;
      sram_dout <= 16'd0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      addr_r    <= addr_s;
      data_r    <= data_s;
      rw_r      <= rw_s;
      sdtr      <= sdtr_s;
      srdy      <= srdy_s;
      sram_nce  <= nce_s;
      sram_noe  <= noe_s;
      sram_nwe  <= nwe_s;
      sram_doe  <= doe_s;
      sram_addr <= sram_addr_s;
      sram_dout <= dout_s;
    end
  end

endmodule

// File: tb/tb_sram_ctl.sv
// Directed bench for sram_ctl: three instances (0, 1 and 15 wait states), an SRAM
// array model on the default instance and address-pattern data on the others.
module tb_sram_ctl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] saddr, sdtw;
  logic        srw;
  logic        sval0, sval1, sval15;

  logic        srdy0, srdy1, srdy15;
  logic [31:0] sdtr0, sdtr1, sdtr15;
  logic [17:0] addr0, addr1, addr15;
  logic [15:0] din0, din1, din15, dout0, dout1, dout15;
  logic        doe0, doe1, doe15, nce0, nce1, nce15, noe0, noe1, noe15, nwe0, nwe1, nwe15;

  logic [15:0] mem [0:255];
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  sram_ctl #(.ADDR_WIDTH(18), .WAIT_STATES(1)) u_w1 (
    .clk(clk), .reset(reset), .sval(sval1), .srdy(srdy1), .saddr(saddr), .sdtw(sdtw),
    .sdtr(sdtr1), .srw(srw), .sram_addr(addr1), .sram_din(din1), .sram_dout(dout1),
    .sram_doe(doe1), .sram_nce(nce1), .sram_noe(noe1), .sram_nwe(nwe1));

  sram_ctl #(.ADDR_WIDTH(18), .WAIT_STATES(0)) u_w0 (
    .clk(clk), .reset(reset), .sval(sval0), .srdy(srdy0), .saddr(saddr), .sdtw(sdtw),
    .sdtr(sdtr0), .srw(srw), .sram_addr(addr0), .sram_din(din0), .sram_dout(dout0),
    .sram_doe(doe0), .sram_nce(nce0), .sram_noe(noe0), .sram_nwe(nwe0));

  sram_ctl #(.ADDR_WIDTH(18), .WAIT_STATES(15)) u_w15 (
    .clk(clk), .reset(reset), .sval(sval15), .srdy(srdy15), .saddr(saddr), .sdtw(sdtw),
    .sdtr(sdtr15), .srw(srw), .sram_addr(addr15), .sram_din(din15), .sram_dout(dout15),
    .sram_doe(doe15), .sram_nce(nce15), .sram_noe(noe15), .sram_nwe(nwe15));

  // SRAM models: real array on the default instance, {A5^addr, addr} pattern elsewhere.
  assign din1  = (!nce1 && !noe1) ? mem[addr1[7:0]] : 16'h0000;
  assign din0  = (!nce0 && !noe0) ? {8'hA5 ^ addr0[7:0], addr0[7:0]} : 16'h0000;
  assign din15 = (!nce15 && !noe15) ? {8'hA5 ^ addr15[7:0], addr15[7:0]} : 16'h0000;

  always @(posedge clk) begin
    if (!nce1 && !nwe1 && doe1) mem[addr1[7:0]] <= dout1;
  end

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic get_srdy(input int sel);
    case (sel)
      0:       return srdy0;
      2:       return srdy15;
      default: return srdy1;
    endcase
  endfunction

  function automatic logic [31:0] get_sdtr(input int sel);
    case (sel)
      0:       return sdtr0;
      2:       return sdtr15;
      default: return sdtr1;
    endcase
  endfunction

  // One transaction on instance sel; inputs are scrambled and sval dropped after acceptance.
  task automatic run_txn(input int sel, input logic rw, input logic [31:0] a, input logic [31:0] d,
                         output int lat, output logic [31:0] rd,
                         output logic [7:0] noe_t, output logic [7:0] nwe_t, output logic [7:0] doe_t);
    int cyc;
    @(negedge clk);
    saddr = a; sdtw = d; srw = rw;
    sval0 = (sel == 0); sval1 = (sel == 1); sval15 = (sel == 2);
    @(posedge clk); #1;
    sval0 = 1'b0; sval1 = 1'b0; sval15 = 1'b0;
    saddr = ~a; sdtw = ~d; srw = ~rw;
    cyc = 1; lat = 0; noe_t = 8'h00; nwe_t = 8'h00; doe_t = 8'h00;
    while (lat == 0 && cyc < 100) begin
      if (cyc <= 8) begin
        noe_t[cyc-1] = noe1; nwe_t[cyc-1] = nwe1; doe_t[cyc-1] = doe1;
      end
      if (get_srdy(sel)) begin
        lat = cyc;
      end else begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    rd = get_sdtr(sel);
    @(posedge clk); #1;
    check_value("srdy_single_pulse", {31'd0, get_srdy(sel)}, 32'd0);
  endtask

  initial begin
    int          lat, cyc, t1, t2;
    logic [31:0] rd;
    logic [7:0]  noe_t, nwe_t, doe_t;
    logic        seen;

    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[8] = 16'hBEEF; mem[9] = 16'hDEAD;
    reset = 1'b1; sval0 = 1'b0; sval1 = 1'b0; sval15 = 1'b0;
    saddr = 32'd0; sdtw = 32'd0; srw = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_value("rst_srdy", {31'd0, srdy1}, 32'd0);
    check_value("rst_sdtr", sdtr1, 32'd0);
    check_value("rst_strobes", {28'd0, nce1, noe1, nwe1, doe1}, 32'h0000_000E);
    check_value("rst_addr", {14'd0, addr1}, 32'd0);
    check_value("rst_dout", {16'd0, dout1}, 32'd0);
    reset = 1'b0;

    run_txn(1, 1'b0, 32'h0000_0010, 32'h0, lat, rd, noe_t, nwe_t, doe_t);
    check_value("rd_w1_data", rd, 32'hDEADBEEF);
    check_value("rd_w1_latency", 32'(lat), 32'd6);
    check_value("rd_w1_noe", {24'd0, noe_t}, 32'h0000_0020);
    check_value("rd_w1_nwe", {24'd0, nwe_t}, 32'h0000_003F);
    check_value("rd_w1_doe", {24'd0, doe_t}, 32'h0000_0000);

    run_txn(1, 1'b1, 32'h0000_0020, 32'h1234_5678, lat, rd, noe_t, nwe_t, doe_t);
    check_value("wr_mem16", {16'd0, mem[16]}, 32'h0000_5678);
    check_value("wr_mem17", {16'd0, mem[17]}, 32'h0000_1234);
    check_value("wr_sdtr_kept", rd, 32'hDEADBEEF);
    check_value("wr_latency", 32'(lat), 32'd6);
    check_value("wr_noe", {24'd0, noe_t}, 32'h0000_003F);
    check_value("wr_nwe_gap_high", {24'd0, nwe_t}, 32'h0000_0024);
    check_value("wr_doe", {24'd0, doe_t}, 32'h0000_001F);

    run_txn(0, 1'b0, 32'h0000_0024, 32'h0, lat, rd, noe_t, nwe_t, doe_t);
    check_value("rd_w0_data", rd, 32'hB613B712);
    check_value("rd_w0_latency", 32'(lat), 32'd4);

    run_txn(2, 1'b0, 32'h0000_0030, 32'h0, lat, rd, noe_t, nwe_t, doe_t);
    check_value("rd_w15_data", rd, 32'hBC19BD18);
    check_value("rd_w15_latency", 32'(lat), 32'd34);

    run_txn(1, 1'b0, 32'hFFF8_0012, 32'h0, lat, rd, noe_t, nwe_t, doe_t);
    check_value("rd_alias_data", rd, 32'hDEADBEEF);

    // Reset during ACC1 of a write.
    @(negedge clk);
    saddr = 32'h0000_0040; sdtw = 32'hCAFE_F00D; srw = 1'b1; sval1 = 1'b1;
    @(posedge clk); #1;
    sval1 = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check_value("abort_in_acc1", {28'd0, nce1, noe1, nwe1, doe1}, 32'h0000_0005);
    reset = 1'b1;
    @(posedge clk); #1;
    check_value("abort_strobes", {28'd0, nce1, noe1, nwe1, doe1}, 32'h0000_000E);
    check_value("abort_srdy", {31'd0, srdy1}, 32'd0);
    check_value("abort_sdtr", sdtr1, 32'd0);
    check_value("abort_addr", {14'd0, addr1}, 32'd0);
    reset = 1'b0;
    seen = 1'b0;
    repeat (8) begin @(posedge clk); #1; seen = seen | srdy1; end
    check_value("abort_no_srdy", {31'd0, seen}, 32'd0);

    run_txn(1, 1'b0, 32'h0000_0010, 32'h0, lat, rd, noe_t, nwe_t, doe_t);
    check_value("rd_after_abort", rd, 32'hDEADBEEF);

    // sval held high: the second request is only taken in the IDLE after DONE.
    @(negedge clk);
    saddr = 32'h0000_0010; srw = 1'b0; sval1 = 1'b1;
    cyc = 0; t1 = 0; t2 = 0;
    while (t2 == 0 && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
      if (srdy1) begin
        if (t1 == 0) t1 = cyc;
        else t2 = cyc;
      end
    end
    sval1 = 1'b0;
    check_value("b2b_first_latency", 32'(t1), 32'd6);
    check_value("b2b_gap", 32'(t2 - t1), 32'd7);
    check_value("b2b_data", sdtr1, 32'hDEADBEEF);
    seen = 1'b0;
    repeat (10) begin @(posedge clk); #1; seen = seen | srdy1; end
    check_value("b2b_no_extra", {31'd0, seen}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
